// File: rtl/multiport_register_file.sv
// Parametrised multi-port register file: registered, write-first reads and a zeroing sweep.
// Optional RF_ZERO_REG_EN hardwires entry 0 to zero.
module multiport_register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic [NUM_RD-1:0]        read_en,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [NUM_WR-1:0]        write_en,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata
);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   wr_addr  [NUM_WR];
  logic [DATA_W-1:0]   wr_data  [NUM_WR];
  logic [NUM_WR-1:0]   wr_valid;

  // Sweep sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == StIdle);
  end

  // Write-port decode; writes only take effect while the array is ready.
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_addr[w]  = waddr[w*ADDR_W +: ADDR_W];
      wr_data[w]  = wdata[w*DATA_W +: DATA_W];
      wr_valid[w] = ready_q && write_en[w];
`ifdef RF_ZERO_REG_EN
      if (wr_addr[w] == '0) begin
        wr_valid[w] = 1'b0;
      end
`endif
    end
  end

  // Read path: array value, overridden by the highest-index matching write (write-first).
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    rdata_d = rdata_q;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = raddr[p*ADDR_W +: ADDR_W];
      rv = mem_q[ra];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_valid[w] && (wr_addr[w] == ra)) begin
          rv = wr_data[w];
        end
      end
`ifdef RF_ZERO_REG_EN
      if (ra == '0) begin
        rv = '0;
      end
`endif
      if (ready_q && read_en[p]) begin
        rdata_d[p*DATA_W +: DATA_W] = rv;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Array storage is deliberately not reset; the sweep initialises it.
  // Ascending port order makes the highest-index colliding write land last.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_valid[w]) begin
          mem_q[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

  ready_matches_state_a: assert property (@(posedge clk) disable iff (!reset_n)
    ready_q == (state_q == StIdle));

  no_write_while_clearing_a: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StClear) |-> (wr_valid == '0));

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file with two write ports: table vectors, model scoreboard,
// and hand-written sweep/reset sequences. Handles both RF_ZERO_REG_EN builds.
module tb_multiport_register_file;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned NUM_WR = 2;
  localparam int unsigned ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     clear_req;
  logic                     ready;
  logic [NUM_RD-1:0]        read_en;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_WR-1:0]        write_en;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;

  multiport_register_file #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .ready     (ready),
    .read_en   (read_en),
    .raddr     (raddr),
    .rdata     (rdata),
    .write_en  (write_en),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [31:0] exp0, exp1;
  } vec_t;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd  [NUM_RD];
  vec_t        tbl [13];
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef RF_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] re, input logic [4:0] ra0,
                              input logic [4:0] ra1, input logic [1:0] we, input logic [4:0] wa0,
                              input logic [31:0] wd0, input logic [4:0] wa1,
                              input logic [31:0] wd1, input logic [31:0] exp0,
                              input logic [31:0] exp1);
    vec_t v;
    v.name = n; v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.we = we;
    v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.exp0 = exp0; v.exp1 = exp1;
    return v;
  endfunction

  function automatic bit wr_ok(input logic en, input logic [4:0] a);
    return en && !(ZeroReg && a == 5'd0);
  endfunction

  task automatic idle_inputs();
    clear_req = 1'b0;
    read_en   = '0;
    write_en  = '0;
    raddr     = '0;
    waddr     = '0;
    wdata     = '0;
  endtask

  // One operational cycle: drive, push expectations, clock, pop and compare.
  task automatic apply(input vec_t v, input bit use_model);
    logic [31:0] e [NUM_RD];
    logic [4:0]  ra;
    exp_t        x;
    @(negedge clk);
    read_en  = v.re;
    raddr    = {v.ra1, v.ra0};
    write_en = v.we;
    waddr    = {v.wa1, v.wa0};
    wdata    = {v.wd1, v.wd0};
    for (int p = 0; p < NUM_RD; p++) begin
      if (use_model) begin
        ra = (p == 0) ? v.ra0 : v.ra1;
        if (v.re[p]) begin
          e[p] = model_mem[ra];
          if (wr_ok(v.we[0], v.wa0) && v.wa0 == ra) e[p] = v.wd0;
          if (wr_ok(v.we[1], v.wa1) && v.wa1 == ra) e[p] = v.wd1;
          if (ZeroReg && ra == 5'd0) e[p] = '0;
        end else begin
          e[p] = model_rd[p];
        end
      end else begin
        e[p] = (p == 0) ? v.exp0 : v.exp1;
      end
      x.name = $sformatf("%s/p%0d", v.name, p);
      x.port = p;
      x.val  = e[p];
      sb.push_back(x);
      model_rd[p] = e[p];
    end
    if (wr_ok(v.we[0], v.wa0)) model_mem[v.wa0] = v.wd0;
    if (wr_ok(v.we[1], v.wa1)) model_mem[v.wa1] = v.wd1;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check(x.name, rdata[x.port*DATA_W +: DATA_W], x.val);
    end
  endtask

  // Runs n sweep edges with reads and writes held active (both must be ignored).
  task automatic sweep(input string tag, input int n, input int clr_at,
                       input logic [31:0] h0, input logic [31:0] h1);
    read_en  = 2'b11;
    raddr    = {5'd1, 5'd1};
    write_en = 2'b01;
    waddr    = {5'd0, 5'd1};
    wdata    = {32'h0, 32'hFFFF_0001};
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s ready e%0d", tag, k), {31'b0, ready}, 32'(k == int'(DEPTH)));
      check($sformatf("%s rdata0 e%0d", tag, k), rdata[31:0], h0);
      check($sformatf("%s rdata1 e%0d", tag, k), rdata[63:32], h1);
      clear_req = (k == clr_at);
    end
    idle_inputs();
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    for (int p = 0; p < NUM_RD; p++) model_rd[p] = '0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      apply(mk($sformatf("%s a%0d", tag, a), 2'b11, 5'(a), 5'(DEPTH - 1 - a), 2'b00,
               5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0), 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [31:0] ones = '1;
    logic [31:0] pat;

    tbl[0]  = mk("sync read 7",     2'b11, 5'd7,  5'd7,  2'b00, 5'd0,  32'h0,
                 5'd0,  32'h0,        32'h0,        32'h0);
    tbl[1]  = mk("bypass addr 5",   2'b01, 5'd5,  5'd0,  2'b01, 5'd5,  32'hDEADBEEF,
                 5'd0,  32'h0,        32'hDEADBEEF, 32'h0);
    tbl[2]  = mk("read back 5",     2'b10, 5'd0,  5'd5,  2'b00, 5'd0,  32'h0,
                 5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
    tbl[3]  = mk("collide addr 3",  2'b00, 5'd0,  5'd0,  2'b11, 5'd3,  32'h1111,
                 5'd3,  32'h2222,     32'hDEADBEEF, 32'hDEADBEEF);
    tbl[4]  = mk("read collided",   2'b11, 5'd3,  5'd3,  2'b00, 5'd0,  32'h0,
                 5'd0,  32'h0,        32'h2222,     32'h2222);
    tbl[5]  = mk("hold no rd_en",   2'b00, 5'd9,  5'd9,  2'b00, 5'd0,  32'h0,
                 5'd0,  32'h0,        32'h2222,     32'h2222);
    tbl[6]  = mk("collide bypass",  2'b01, 5'd4,  5'd0,  2'b11, 5'd4,  32'hAAAA,
                 5'd4,  32'hBBBB,     32'hBBBB,     32'h2222);
    tbl[7]  = mk("read 4 p1",       2'b10, 5'd0,  5'd4,  2'b00, 5'd0,  32'h0,
                 5'd0,  32'h0,        32'hBBBB,     32'hBBBB);
    tbl[8]  = mk("cross bypass",    2'b11, 5'd11, 5'd10, 2'b11, 5'd10, 32'hCAFE0000,
                 5'd11, 32'h0000F00D, 32'h0000F00D, 32'hCAFE0000);
    tbl[9]  = mk("read 10/11",      2'b11, 5'd10, 5'd11, 2'b00, 5'd0,  32'h0,
                 5'd0,  32'h0,        32'hCAFE0000, 32'h0000F00D);
    tbl[10] = mk("top addr 31",     2'b10, 5'd0,  5'd31, 2'b10, 5'd0,  32'h0,
                 5'd31, 32'h80000001, 32'hCAFE0000, 32'h80000001);
`ifdef RF_ZERO_REG_EN
    tbl[11] = mk("zero reg bypass", 2'b01, 5'd0,  5'd0,  2'b01, 5'd0,  32'hFFFFFFFF,
                 5'd0,  32'h0,        32'h0,        32'h80000001);
    tbl[12] = mk("zero reg later",  2'b11, 5'd0,  5'd0,  2'b00, 5'd0,  32'h0,
                 5'd0,  32'h0,        32'h0,        32'h0);
`else
    tbl[11] = mk("addr 0 bypass",   2'b01, 5'd0,  5'd0,  2'b01, 5'd0,  32'hFFFFFFFF,
                 5'd0,  32'h0,        32'hFFFFFFFF, 32'h80000001);
    tbl[12] = mk("addr 0 later",    2'b11, 5'd0,  5'd0,  2'b00, 5'd0,  32'h0,
                 5'd0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF);
`endif

    // Reset held: inputs toggling must not matter.
    reset_n   = 1'b0;
    clear_req = 1'b1;
    read_en   = 2'b11;
    write_en  = 2'b11;
    raddr     = {5'd2, 5'd1};
    waddr     = {5'd2, 5'd1};
    wdata     = {32'h12345678, 32'h9ABCDEF0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset ready c%0d", i), {31'b0, ready}, 32'h0);
      check($sformatf("reset rdata0 c%0d", i), rdata[31:0], 32'h0);
      check($sformatf("reset rdata1 c%0d", i), rdata[63:32], 32'h0);
    end
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    sweep("init sweep", DEPTH, 5, 32'h0, 32'h0);
    model_clear();
    read_all("post-reset read");

    // Walking ones then walking zeros on every register via both write ports.
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 0; k < 64; k++) begin
        pat = (k < 32) ? (ones >> (31 - k)) : (ones << (k - 31));
        if (k % 2 == 0)
          v = mk("walk wr", 2'b00, 5'd0, 5'd0, 2'b01, 5'(r), pat, 5'd0, 32'h0, 32'h0, 32'h0);
        else
          v = mk("walk wr", 2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 32'h0, 5'(r), pat, 32'h0, 32'h0);
        apply(v, 1'b1);
        v = mk($sformatf("walk r%0d k%0d", r, k), 2'b00, 5'(r), 5'(r), 2'b00, 5'd0, 32'h0,
               5'd0, 32'h0, 32'h0, 32'h0);
        v.re = (k % 3 == 0) ? 2'b01 : (k % 3 == 1) ? 2'b10 : 2'b11;
        apply(v, 1'b1);
      end
    end

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i], 1'b0);
    end

    // Fill, then clear with a concurrent write, reset mid-sweep and an ignored clear_req.
    for (int a = 0; a < DEPTH; a++) begin
      apply(mk("fill", 2'b00, 5'd0, 5'd0, 2'b01, 5'(a), 32'hA5000000 | 32'(a), 5'd0, 32'h0,
               32'h0, 32'h0), 1'b1);
    end
    apply(mk("pre-clear read 2", 2'b11, 5'd2, 5'd2, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
             32'h0, 32'h0), 1'b1);
    @(negedge clk);
    clear_req = 1'b1;
    write_en  = 2'b01;
    waddr     = {5'd0, 5'd6};
    wdata     = {32'h0, 32'h66666666};
    @(posedge clk);
    #1;
    check("clear_req ready drop", {31'b0, ready}, 32'h0);
    check("clear_req rdata0 hold", rdata[31:0], model_rd[0]);
    idle_inputs();
    sweep("clear sweep", 10, 0, 32'hA5000002, 32'hA5000002);
    reset_n = 1'b0;
    #1;
    check("mid-sweep reset ready", {31'b0, ready}, 32'h0);
    check("mid-sweep reset rdata0", rdata[31:0], 32'h0);
    check("mid-sweep reset rdata1", rdata[63:32], 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    sweep("restart sweep", DEPTH, 20, 32'h0, 32'h0);
    model_clear();
    read_all("post-clear read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised successor to the 2R/1W 32x32 register_file.
- Configurable data width, depth, read-port count and write-port count.
- Registered (1-cycle) reads with same-cycle write-to-read bypass, per-port read enables, and a deterministic multi-port write-collision rule.
- Built-in clear sequencer sweeps every entry to zero after reset or on request.
- Sits in the core datapath between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, bits per register.
- DEPTH, 32, number of registers; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- NUM_RD, 2, read ports.
- NUM_WR, 1, write ports.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  pulse in IDLE starts a zeroing sweep.
- ready  out  1  high when the array accepts reads and writes.
- read_en  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  packed registered read data; port p at [p*DATA_W +: DATA_W].
- write_en  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  packed write addresses.
- wdata  in  NUM_WR*DATA_W  packed write data.

Behaviour:
- Reset values (reset_n low): rdata=0, ready=0, FSM=CLEAR, clear counter=0. Array contents are undefined until the sweep completes.
- FSM states:
  - CLEAR: each cycle, array[cnt]<=0 and cnt<=cnt+1. When cnt==DEPTH-1, go to IDLE next cycle.
  - IDLE: ready=1. If clear_req=1, go to CLEAR with cnt=0 next cycle.
- Sweep length is exactly DEPTH cycles; ready rises on the first edge after the last entry is cleared.
- ready is registered: 0 in CLEAR, 1 in IDLE.
- While ready=0: write_en and read_en are ignored; rdata holds its value (0 after reset).
- clear_req arriving in CLEAR is ignored and does not restart the sweep.
- Reset asserted mid-sweep or mid-operation returns immediately to the reset values; the sweep restarts from entry 0 after release.
- Write (ready=1): on a clock edge, for each port w with write_en[w]=1, array[waddr_w] <= wdata_w.
- Write collision: if several enabled write ports share an address, the highest-index port wins.
- Read (ready=1): read_en[p]=1 at edge N makes rdata_p valid after edge N with the contents of raddr_p.
- Read latency is 1 cycle.
- With read_en[p]=0, rdata_p holds its previous value.
- Bypass: if an enabled write in the same cycle targets raddr_p, rdata_p takes that cycle's wdata (highest-index matching write port). This makes the block write-first.
- Read ports are independent; any number may read the same address in the same cycle.
- clear_req and writes in the same IDLE cycle: the writes commit, then the sweep overwrites them.
- All widths are unsigned; there is no arithmetic on data.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to zero; writes to address 0 are discarded.
  - Reads of address 0 return 0, including under bypass.
  - Writes to address 0 do not participate in collision resolution.
- Undefined: entry 0 is an ordinary register.

Test Plan:
- Reset release, DEPTH=32 -> ready=0 for exactly 32 cycles, then 1. Every address then reads 0 on all ports. rdata=0 throughout the sweep.
- Walking ones, then walking zeros, on each register (wdata shifts 32'h00000001 ... 32'hFFFFFFFF ... 32'h00000000) -> both ports return the written value one cycle after read_en, reading singly and together.
- Same-cycle write addr 5 = 32'hDEADBEEF with read addr 5 on port 0 -> rdata_0 = 32'hDEADBEEF on the next cycle (bypass).
- NUM_WR=2, both ports write addr 3 (port0 = 32'h1111, port1 = 32'h2222) -> a later read returns 32'h2222. read_en=0 on the following cycle -> rdata unchanged.
- clear_req after filling all entries, with reset_n pulsed low at sweep cycle 10 -> ready stays 0 and the sweep restarts. After a full 32-cycle sweep, all entries read 0.
- RF_ZERO_REG_EN defined: write addr 0 = 32'hFFFFFFFF with a simultaneous read of addr 0 -> rdata=0 on that read and on later reads.
